hp_video_capture: RTL and testbench

- Upstream neighbour of the VGA transmit stage: samples the HP instrument's raw video (HP_HS, HP_VS, HP_VIDEO, HP_DIM) and writes one 8-bit intensity per stored pixel into the shared frame BRAM.
- The transmit stage reads this BRAM linearly from address 0, so pixels are packed row-major with no gaps.
- Capture runs continuously, frame after frame, while ENABLE is high.

---
 rtl/hp_video_capture.sv | 204 ++++++++++++++++++++
 tb/tb_hp_video_capture.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/hp_video_capture.sv
// Samples the HP instrument's raw video and writes one 8-bit intensity per
// stored pixel, row-major from address 0, into the frame BRAM read by the VGA stage.
module hp_video_capture #(
  parameter int H_PIXELS    = 128,
  parameter int V_LINES     = 128,
  parameter int H_BACKPORCH = 40,
  parameter int V_BACKPORCH = 8,
  parameter int SAMPLE_DIV  = 2,
  parameter int ADDR_W      = 14
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic              ENABLE,
  input  logic              HP_HS,
  input  logic              HP_VS,
  input  logic              HP_VIDEO,
  input  logic              HP_DIM,
  output logic [ADDR_W-1:0] BRAM_ADDR,
  output logic [7:0]        BRAM_DIN,
  output logic              BRAM_WE,
  output logic              FRAME_DONE,
  output logic              SYNC_ERR
);

  localparam int CW = 16;
  localparam logic [CW-1:0] H_PIX    = CW'(H_PIXELS);
  localparam logic [CW-1:0] V_LIN    = CW'(V_LINES);
  localparam logic [CW-1:0] H_BP     = CW'(H_BACKPORCH);
  localparam logic [CW-1:0] V_BP     = CW'(V_BACKPORCH);
  localparam logic [CW-1:0] DIV_LAST = CW'(SAMPLE_DIV - 1);

  typedef enum logic [2:0] {IDLE, VSKIP, HWAIT, HPORCH, ACTIVE, DONE} state_t;

  state_t state, state_next;

  logic [2:0] hs_sync, vs_sync;
  logic [1:0] vid_sync, dim_sync;
  logic       hs_rise, vs_rise;
  logic [7:0] pix;

  logic [CW-1:0] x_cnt, line_cnt, skip_cnt, porch_cnt, div_cnt;
  logic [CW-1:0] line_cur, x_base;
  logic do_sample, start_line, line_end, restart, err, skip_inc;
  logic porch_load, porch_dec, jump, done;

  // Two flops for metastability, the third only as the edge-detect reference.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      hs_sync  <= '0;
      vs_sync  <= '0;
      vid_sync <= '0;
      dim_sync <= '0;
    end else begin
      hs_sync  <= {hs_sync[1:0], HP_HS};
      vs_sync  <= {vs_sync[1:0], HP_VS};
      vid_sync <= {vid_sync[0], HP_VIDEO};
      dim_sync <= {dim_sync[0], HP_DIM};
    end
  end

  assign hs_rise = hs_sync[1] & ~hs_sync[2];
  assign vs_rise = vs_sync[1] & ~vs_sync[2];
  assign pix     = vid_sync[1] ? (dim_sync[1] ? 8'h80 : 8'hFF) : 8'h00;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    // NOTE: every signal gets a default first so no path can infer a latch.
    state_next = state;
    do_sample  = 1'b0;
    start_line = 1'b0;
    line_end   = 1'b0;
    restart    = 1'b0;
    err        = 1'b0;
    skip_inc   = 1'b0;
    porch_load = 1'b0;
    porch_dec  = 1'b0;
    jump       = 1'b0;
    done       = 1'b0;
    line_cur   = line_cnt;
    x_base     = x_cnt;

    if (!ENABLE) begin
      state_next = IDLE;
    end else if (vs_rise && state != IDLE && state != DONE) begin
      // VS outranks any simultaneous HS; an unexpected one is flagged.
      err        = (state != VSKIP);
      restart    = 1'b1;
      state_next = (V_BP == '0) ? HWAIT : VSKIP;
    end else begin
      unique case (state)
        IDLE: if (vs_rise) begin
          restart    = 1'b1;
          state_next = (V_BP == '0) ? HWAIT : VSKIP;
        end
        VSKIP: if (hs_rise) begin
          skip_inc = 1'b1;
          if (skip_cnt + 16'd1 >= V_BP) state_next = HWAIT;
        end
        HWAIT:  if (hs_rise) start_line = 1'b1;
        HPORCH: begin
          if (porch_cnt <= 16'd1) begin
            do_sample  = 1'b1;
            state_next = ACTIVE;
          end else begin
            porch_dec = 1'b1;
          end
        end
        ACTIVE: begin
          if (hs_rise) begin
            // Short line: abandon the rest and treat this edge as the next line's HS.
            err      = 1'b1;
            jump     = 1'b1;
            line_cur = line_cnt + 16'd1;
            x_base   = '0;
            if (line_cur == V_LIN) state_next = DONE;
            else                   start_line = 1'b1;
          end else if (div_cnt == DIV_LAST) begin
            do_sample = 1'b1;
          end
        end
        DONE: begin
          done       = 1'b1;
          state_next = IDLE;
        end
        default: state_next = IDLE;
      endcase

      if (start_line) begin
        if (H_BP == '0) begin
          do_sample  = 1'b1;
          state_next = ACTIVE;
        end else begin
          porch_load = 1'b1;
          state_next = HPORCH;
        end
      end

      if (do_sample && (x_base + 16'd1 == H_PIX)) begin
        line_end   = 1'b1;
        state_next = (line_cur + 16'd1 == V_LIN) ? DONE : HWAIT;
      end
    end
  end

  // Later assignments in this block deliberately override earlier ones.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      BRAM_ADDR  <= '0;
      BRAM_DIN   <= '0;
      BRAM_WE    <= 1'b0;
      FRAME_DONE <= 1'b0;
      SYNC_ERR   <= 1'b0;
      x_cnt      <= '0;
      line_cnt   <= '0;
      skip_cnt   <= '0;
      porch_cnt  <= '0;
      div_cnt    <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      BRAM_WE    <= 1'b0;
      FRAME_DONE <= done;
      SYNC_ERR   <= err;

      if (BRAM_WE && ENABLE) BRAM_ADDR <= BRAM_ADDR + 1'b1;
      if (state == ACTIVE)   div_cnt   <= div_cnt + 16'd1;
      if (skip_inc)          skip_cnt  <= skip_cnt + 16'd1;

      if (porch_load)     porch_cnt <= H_BP;
      else if (porch_dec) porch_cnt <= porch_cnt - 16'd1;

      if (restart) begin
        line_cnt  <= '0;
        skip_cnt  <= '0;
        x_cnt     <= '0;
        BRAM_ADDR <= '0;
      end

      if (jump) begin
        line_cnt  <= line_cur;
        x_cnt     <= '0;
        BRAM_ADDR <= ADDR_W'(line_cur) * ADDR_W'(H_PIXELS);
      end

      if (do_sample) begin
        BRAM_WE  <= 1'b1;
        BRAM_DIN <= pix;
        x_cnt    <= x_base + 16'd1;
        div_cnt  <= '0;
      end

      if (line_end) begin
        line_cnt <= line_cur + 16'd1;
        x_cnt    <= '0;
      end

      if (done) BRAM_ADDR <= '0;
    end
  end

endmodule

// File: tb/tb_hp_video_capture.sv
// Directed bench for hp_video_capture: a 4x2 frame capture (SAMPLE_DIV=1) and a
// twin instance with SAMPLE_DIV=3 sharing the same stimulus.
module tb_hp_video_capture;

  localparam int AW = 14;

  logic          CLK, RESET_N, ENABLE, HP_HS, HP_VS, HP_VIDEO, HP_DIM;
  logic [AW-1:0] addr, addr3;
  logic [7:0]    din, din3;
  logic          we, we3, fd, fd3, serr, serr3;

  hp_video_capture #(.H_PIXELS(4), .V_LINES(2), .H_BACKPORCH(2), .V_BACKPORCH(1),
                     .SAMPLE_DIV(1), .ADDR_W(AW)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .ENABLE(ENABLE), .HP_HS(HP_HS), .HP_VS(HP_VS),
    .HP_VIDEO(HP_VIDEO), .HP_DIM(HP_DIM), .BRAM_ADDR(addr), .BRAM_DIN(din),
    .BRAM_WE(we), .FRAME_DONE(fd), .SYNC_ERR(serr));

  hp_video_capture #(.H_PIXELS(4), .V_LINES(2), .H_BACKPORCH(2), .V_BACKPORCH(1),
                     .SAMPLE_DIV(3), .ADDR_W(AW)) dut3 (
    .CLK(CLK), .RESET_N(RESET_N), .ENABLE(ENABLE), .HP_HS(HP_HS), .HP_VS(HP_VS),
    .HP_VIDEO(HP_VIDEO), .HP_DIM(HP_DIM), .BRAM_ADDR(addr3), .BRAM_DIN(din3),
    .BRAM_WE(we3), .FRAME_DONE(fd3), .SYNC_ERR(serr3));

  typedef struct {int cyc; logic [AW-1:0] addr; logic [7:0] din;} wr_t;
  typedef struct {logic video; logic dim; logic [7:0] din;} pix_vec_t;

  wr_t wq[$], wq3[$];
  int  done_q[$], done3_q[$], err_q[$], err3_q[$];
  int  cyc = 0;
  int  tests = 0;
  int  fails = 0;

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  always @(posedge CLK) cyc <= cyc + 1;

  always @(negedge CLK) begin
    if (we)    wq.push_back('{cyc, addr, din});
    if (we3)   wq3.push_back('{cyc, addr3, din3});
    if (fd)    done_q.push_back(cyc);
    if (fd3)   done3_q.push_back(cyc);
    if (serr)  err_q.push_back(cyc);
    if (serr3) err3_q.push_back(cyc);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic clear_logs();
    wq.delete(); wq3.delete();
    done_q.delete(); done3_q.delete(); err_q.delete(); err3_q.delete();
  endtask

  // Raw edge driven just after posedge 'at'; the FSM reacts at posedge at+3.
  task automatic hs_pulse(output int at);
    at = cyc;
    HP_HS = 1'b1;
    tick(2);
    HP_HS = 1'b0;
  endtask

  task automatic vs_pulse();
    HP_VS = 1'b1;
    tick(2);
    HP_VS = 1'b0;
    tick(4);
  endtask

  task automatic line(output int at, input int gap);
    hs_pulse(at);
    tick(gap - 2);
  endtask

  // VS then the single back-porch HS; leaves the DUT waiting for line 0.
  task automatic start_frame();
    int t;
    vs_pulse();
    hs_pulse(t);
    tick(4);
  endtask

  pix_vec_t vecs[4];
  int h0, h1, h2, ha, hb;

  initial begin
    vecs[0] = '{1'b0, 1'b1, 8'h00};
    vecs[1] = '{1'b1, 1'b1, 8'h80};
    vecs[2] = '{1'b1, 1'b0, 8'hFF};
    vecs[3] = '{1'b0, 1'b0, 8'h00};

    RESET_N = 1'b0; ENABLE = 1'b0; HP_HS = 1'b0; HP_VS = 1'b0;
    HP_VIDEO = 1'b0; HP_DIM = 1'b0;
    tick(3);
    check("reset_addr", 32'(addr), 32'h0);
    check("reset_din", 32'(din), 32'h0);
    check("reset_we", 32'(we), 32'h0);
    check("reset_frame_done", 32'(fd), 32'h0);
    check("reset_sync_err", 32'(serr), 32'h0);
    RESET_N = 1'b1;
    tick(2);

    // Nominal frame: both instances, full-intensity video.
    ENABLE = 1'b1; HP_VIDEO = 1'b1; HP_DIM = 1'b0;
    clear_logs();
    start_frame();
    line(h0, 20);
    line(h1, 20);
    tick(5);
    check("nom_writes", 32'(wq.size()), 32'd8);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("nom_addr%0d", i), 32'(wq[i].addr), 32'(i));
      check($sformatf("nom_din%0d", i), 32'(wq[i].din), 32'hFF);
    end
    check("nom_first_we_cycle", 32'(wq[0].cyc), 32'(h0 + 5));
    check("nom_done_count", 32'(done_q.size()), 32'd1);
    check("nom_done_cycle", 32'(done_q[0]), 32'(h1 + 9));
    check("nom_sync_err_count", 32'(err_q.size()), 32'd0);
    check("div3_writes", 32'(wq3.size()), 32'd8);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("div3_cycle%0d", i), 32'(wq3[i].cyc),
            32'((i < 4 ? h0 : h1) + 5 + 3 * (i % 4)));
      check($sformatf("div3_addr%0d", i), 32'(wq3[i].addr), 32'(i));
    end
    check("div3_done_count", 32'(done3_q.size()), 32'd1);
    check("div3_done_cycle", 32'(done3_q[0]), 32'(h1 + 15));
    check("div3_sync_err_count", 32'(err3_q.size()), 32'd0);

    // Intensity map: one sample per table row on line 0.
    clear_logs();
    start_frame();
    h0 = cyc;
    HP_HS = 1'b1;
    tick(2);
    HP_HS = 1'b0;
    for (int i = 0; i < 4; i++) begin
      HP_VIDEO = vecs[i].video;
      HP_DIM   = vecs[i].dim;
      tick(1);
    end
    tick(14);
    line(h1, 20);
    tick(5);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("map_din%0d", i), 32'(wq[i].din), 32'(vecs[i].din));
      check($sformatf("map_addr%0d", i), 32'(wq[i].addr), 32'(i));
    end
    check("map_done_count", 32'(done_q.size()), 32'd1);

    // Short line: second HS lands after two pixels of line 0.
    HP_VIDEO = 1'b1; HP_DIM = 1'b1;
    clear_logs();
    start_frame();
    hs_pulse(h0);
    tick(2);
    hs_pulse(h1);
    tick(16);
    check("short_writes", 32'(wq.size()), 32'd6);
    for (int i = 0; i < 6; i++) begin
      check($sformatf("short_addr%0d", i), 32'(wq[i].addr), 32'(i < 2 ? i : i + 2));
      check($sformatf("short_cycle%0d", i), 32'(wq[i].cyc), 32'(i < 2 ? h0 + 5 + i : h0 + 7 + i));
      check($sformatf("short_din%0d", i), 32'(wq[i].din), 32'h80);
    end
    check("short_err_count", 32'(err_q.size()), 32'd1);
    check("short_err_cycle", 32'(err_q[0]), 32'(h0 + 7));
    check("short_done_count", 32'(done_q.size()), 32'd1);
    check("short_done_cycle", 32'(done_q[0]), 32'(h0 + 13));

    // VS arrives during line 1, after the fifth write.
    clear_logs();
    start_frame();
    line(h0, 20);
    hs_pulse(h1);
    tick(1);
    HP_VS = 1'b1;
    tick(2);
    HP_VS = 1'b0;
    tick(10);
    check("vsmid_writes", 32'(wq.size()), 32'd5);
    check("vsmid_last_addr", 32'(wq[4].addr), 32'd4);
    check("vsmid_err_count", 32'(err_q.size()), 32'd1);
    check("vsmid_err_cycle", 32'(err_q[0]), 32'(h1 + 6));
    check("vsmid_no_done", 32'(done_q.size()), 32'd0);
    clear_logs();
    hs_pulse(h2);
    tick(4);
    line(ha, 20);
    line(hb, 20);
    tick(5);
    check("vsmid_next_writes", 32'(wq.size()), 32'd8);
    check("vsmid_next_first_addr", 32'(wq[0].addr), 32'd0);
    check("vsmid_next_first_cycle", 32'(wq[0].cyc), 32'(ha + 5));
    check("vsmid_next_done", 32'(done_q.size()), 32'd1);

    // ENABLE dropped mid-line: writes stop at once.
    clear_logs();
    start_frame();
    hs_pulse(h0);
    tick(4);
    ENABLE = 1'b0;
    tick(1);
    check("en_low_we", 32'(we), 32'd0);
    tick(10);
    check("en_low_writes", 32'(wq.size()), 32'd2);
    check("en_low_no_done", 32'(done_q.size()), 32'd0);
    ENABLE = 1'b1;
    tick(2);

    // Reset mid-line, then VS while disabled, then HS-only while enabled.
    clear_logs();
    start_frame();
    hs_pulse(h0);
    tick(4);
    check("pre_reset_we", 32'(we), 32'd1);
    RESET_N = 1'b0;
    #1;
    check("rst_mid_addr", 32'(addr), 32'h0);
    check("rst_mid_din", 32'(din), 32'h0);
    check("rst_mid_we", 32'(we), 32'h0);
    check("rst_mid_frame_done", 32'(fd), 32'h0);
    check("rst_mid_sync_err", 32'(serr), 32'h0);
    tick(2);
    ENABLE = 1'b0;
    RESET_N = 1'b1;
    clear_logs();
    tick(1);
    vs_pulse();
    line(h1, 20);
    check("dis_vs_writes", 32'(wq.size()), 32'd0);
    ENABLE = 1'b1;
    tick(2);
    line(h1, 20);
    line(h2, 20);
    check("en_hs_only_writes", 32'(wq.size()), 32'd0);
    start_frame();
    line(ha, 20);
    line(hb, 20);
    tick(5);
    check("resume_writes", 32'(wq.size()), 32'd8);
    check("resume_first_addr", 32'(wq[0].addr), 32'd0);
    check("resume_first_cycle", 32'(wq[0].cyc), 32'(ha + 5));
    check("resume_last_addr", 32'(wq[7].addr), 32'd7);
    check("resume_done", 32'(done_q.size()), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
